// File: rtl/l2_message_responder.sv
// L2-side endpoint for L1 data-cache messages.
// Accepts {address, command} messages into a small FIFO, services them in order
// with a per-command modelled latency, returns a line-aligned response and
// keeps saturating per-command completion counters for simulation reporting.
module l2_message_responder #(
   parameter int FIFO_DEPTH    = 4,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2,
   parameter int CNT_W         = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          msg_valid,
   input  logic [61:0]                   msg,
   output logic                          msg_ready,
   output logic                          resp_valid,
   output logic [1:0]                    resp_cmd,
   output logic [59:0]                   resp_addr,
   input  logic                          resp_ready,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              rd_count,
   output logic [CNT_W-1:0]              wr_count,
   output logic [CNT_W-1:0]              rfo_count,
   output logic [CNT_W-1:0]              rtn_count
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int EFF_RD  = (READ_LATENCY  < 1) ? 1 : READ_LATENCY;
   localparam int EFF_WR  = (WRITE_LATENCY < 1) ? 1 : WRITE_LATENCY;
   localparam int MAX_LAT = (EFF_RD > EFF_WR) ? EFF_RD : EFF_WR;
   localparam int LAT_W   = $clog2(MAX_LAT + 1);

   localparam logic [1:0] CMD_RTN = 2'd0;
   localparam logic [1:0] CMD_WR  = 2'd1;
   localparam logic [1:0] CMD_RD  = 2'd2;
   localparam logic [1:0] CMD_RFO = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [61:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level;
   logic [61:0]      head;
   logic             push;
   logic             pop;
   logic             handshake;

   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_load;
   logic [1:0]       cur_cmd;
   logic [59:0]      cur_addr;

   // Full/ready comes purely from registered occupancy, so a pop on the same
   // edge never frees a slot for a push while the FIFO is full.
   assign msg_ready  = (level != LVL_W'(FIFO_DEPTH));
   assign push       = msg_valid && msg_ready;
   assign head       = fifo_mem[rd_ptr];
   assign handshake  = (state == RESP) && resp_ready;

   assign fifo_level = level;
   assign busy       = (state != IDLE) || (level != '0);
   assign resp_valid = (state == RESP);
   assign resp_cmd   = cur_cmd;
   assign resp_addr  = cur_addr & ~60'h3f;

   // Service time for the message at the FIFO head, chosen by its command.
   always_comb begin
      lat_load = LAT_W'(1);
      case (head[1:0])
         CMD_RD, CMD_RFO: lat_load = LAT_W'(EFF_RD);
         CMD_WR:          lat_load = LAT_W'(EFF_WR);
         default:         lat_load = LAT_W'(1);
      endcase
   end

   // Next-state logic: pop in IDLE, count down in WAIT, hold in RESP until taken.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0) begin
               pop        = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == LAT_W'(1)) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= msg;
      end
   end

   // Current message registers and latency countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_cmd  <= '0;
         cur_addr <= '0;
         lat_cnt  <= '0;
      end else if (pop) begin
         cur_cmd  <= head[1:0];
         cur_addr <= head[61:2];
         lat_cnt  <= lat_load;
      end else if ((state == WAIT) && (lat_cnt != LAT_W'(1))) begin
         lat_cnt  <= lat_cnt - 1'b1;
      end
   end

   // Saturating per-command completion counters, bumped on the response handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count  <= '0;
         wr_count  <= '0;
         rfo_count <= '0;
         rtn_count <= '0;
      end else if (handshake) begin
         case (cur_cmd)
            CMD_RD:  if (rd_count  != '1) rd_count  <= rd_count  + 1'b1;
            CMD_WR:  if (wr_count  != '1) wr_count  <= wr_count  + 1'b1;
            CMD_RFO: if (rfo_count != '1) rfo_count <= rfo_count + 1'b1;
            CMD_RTN: if (rtn_count != '1) rtn_count <= rtn_count + 1'b1;
            default: ;
         endcase
      end
   end

endmodule
